// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, decode-field widths, the NOP
// encoding used to clear IF/ID, and the fetch FSM state encoding.
package cpu_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 32;
  localparam int IMM_W   = 17;
  localparam int TGT_W   = 27;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding {instr, pc+1} for a response that arrived
// while IF/ID was full and decode was stalled.
// Ports:
//   i_clock, i_reset_n    clock, async active-low reset
//   i_load                capture i_instr/i_pc (buffer becomes full)
//   i_drain               entry consumed by IF/ID (buffer becomes empty)
//   i_clear               flush on redirect (wins over load/drain)
//   i_instr, i_pc         entry to capture
//   o_full                entry valid
//   o_instr, o_pc         stored entry
module fetch_skid
  import cpu_pkg::*;
#(
  parameter int P_PC_W    = cpu_pkg::PC_W,
  parameter int P_INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_load,
  input  logic                 i_drain,
  input  logic                 i_clear,
  input  logic [P_INSTR_W-1:0] i_instr,
  input  logic [P_PC_W-1:0]    i_pc,
  output logic                 o_full,
  output logic [P_INSTR_W-1:0] o_instr,
  output logic [P_PC_W-1:0]    o_pc
);

  logic                 r_full;
  logic [P_INSTR_W-1:0] r_instr;
  logic [P_PC_W-1:0]    r_pc;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_full  <= 1'b0;
      r_instr <= P_INSTR_W'(NOP_INSTR);
      r_pc    <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register. Keeps the PC, issues
// single-outstanding requests to instruction memory, parks one response in a
// skid entry while decode stalls, and handles branch/jump redirects.
// Ports:
//   i_clock, i_reset_n        clock, async active-low reset
//   o_imem_req, o_imem_addr   fetch request and address (current PC)
//   i_imem_ack, i_imem_data   response strobe and instruction word
//   i_redirect_valid/_pc      taken branch/jump and its target
//   i_id_stall                decode cannot accept; hold IF/ID
//   o_id_valid/_instr/_pc     IF/ID contents; pc is instruction address + 1
//   o_id_imm17, o_id_target27 raw low slices of o_id_instr for the extenders
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 P_PC_W     = cpu_pkg::PC_W,
  parameter int                 P_INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [P_PC_W-1:0]  P_RESET_PC = '0
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  output logic                 o_imem_req,
  output logic [P_PC_W-1:0]    o_imem_addr,
  input  logic                 i_imem_ack,
  input  logic [P_INSTR_W-1:0] i_imem_data,
  input  logic                 i_redirect_valid,
  input  logic [P_PC_W-1:0]    i_redirect_pc,
  input  logic                 i_id_stall,
  output logic                 o_id_valid,
  output logic [P_INSTR_W-1:0] o_id_instr,
  output logic [P_PC_W-1:0]    o_id_pc,
  output logic [IMM_W-1:0]     o_id_imm17,
  output logic [TGT_W-1:0]     o_id_target27
);

  fetch_state_e r_state, w_state_nxt;

  logic [P_PC_W-1:0]    r_pc, w_pc_nxt, w_pc_inc;
  logic                 r_id_valid;
  logic [P_INSTR_W-1:0] r_id_instr;
  logic [P_PC_W-1:0]    r_id_pc;

  logic                 w_req, w_ack;
  logic                 w_skid_load, w_skid_drain, w_skid_clear, w_skid_full;
  logic [P_INSTR_W-1:0] w_skid_instr;
  logic [P_PC_W-1:0]    w_skid_pc;
  logic                 w_ifid_load_mem, w_ifid_load_skid, w_ifid_clear;

  // Natural wrap at 2^P_PC_W.
  assign w_pc_inc = r_pc + P_PC_W'(1);

  // A full skid means IF/ID is full too, so there is nowhere for another
  // response to land: stop requesting until decode drains the skid.
  assign w_req = (r_state == ST_FETCH) && !w_skid_full;
  assign w_ack = w_req && i_imem_ack;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_pc    <= P_RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_skid_load      = 1'b0;
    w_skid_drain     = 1'b0;
    w_skid_clear     = 1'b0;
    w_ifid_load_mem  = 1'b0;
    w_ifid_load_skid = 1'b0;
    w_ifid_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
        if (i_redirect_valid) w_pc_nxt = i_redirect_pc;
      end
      ST_FETCH: begin
        if (i_redirect_valid) begin
          w_pc_nxt     = i_redirect_pc;
          w_ifid_clear = 1'b1;
          w_skid_clear = 1'b1;
          // The old-path response is still coming; swallow it in DROP.
          // A same-cycle ack is simply ignored and we refetch at once.
          if (w_req && !i_imem_ack) w_state_nxt = ST_DROP;
        end else begin
          if (w_ack) w_pc_nxt = w_pc_inc;
          if (!i_id_stall) begin
            if (w_skid_full) begin
              w_ifid_load_skid = 1'b1;
              w_skid_drain     = 1'b1;
            end else if (w_ack) begin
              w_ifid_load_mem = 1'b1;
            end else begin
              w_ifid_clear = 1'b1;
            end
          end else if (w_ack) begin
            if (r_id_valid) w_skid_load     = 1'b1;
            else            w_ifid_load_mem = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (i_redirect_valid) w_pc_nxt = i_redirect_pc;
        if (i_imem_ack) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_id_valid <= 1'b0;
      r_id_instr <= P_INSTR_W'(NOP_INSTR);
      r_id_pc    <= '0;
    end else if (w_ifid_clear) begin
      r_id_valid <= 1'b0;
    end else if (w_ifid_load_mem) begin
      r_id_valid <= 1'b1;
      r_id_instr <= i_imem_data;
      r_id_pc    <= w_pc_inc;
    end else if (w_ifid_load_skid) begin
      r_id_valid <= 1'b1;
      r_id_instr <= w_skid_instr;
      r_id_pc    <= w_skid_pc;
    end
  end

  fetch_skid #(
    .P_PC_W    (P_PC_W),
    .P_INSTR_W (P_INSTR_W)
  ) u_skid (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_load    (w_skid_load),
    .i_drain   (w_skid_drain),
    .i_clear   (w_skid_clear),
    .i_instr   (i_imem_data),
    .i_pc      (w_pc_inc),
    .o_full    (w_skid_full),
    .o_instr   (w_skid_instr),
    .o_pc      (w_skid_pc)
  );

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_pc;
  assign o_id_valid    = r_id_valid;
  assign o_id_instr    = r_id_instr;
  assign o_id_pc       = r_id_pc;
  assign o_id_imm17    = r_id_instr[IMM_W-1:0];
  assign o_id_target27 = r_id_instr[TGT_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        redir = 1'b0;
  logic [11:0] redir_pc = '0;
  logic        stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [11:0] id_pc;
  logic [16:0] id_imm17;
  logic [26:0] id_tgt27;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_ack       (imem_ack),
    .i_imem_data      (imem_data),
    .i_redirect_valid (redir),
    .i_redirect_pc    (redir_pc),
    .i_id_stall       (stall),
    .o_id_valid       (id_valid),
    .o_id_instr       (id_instr),
    .o_id_pc          (id_pc),
    .o_id_imm17       (id_imm17),
    .o_id_target27    (id_tgt27)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {req, addr} and {valid, pc, instr} are compared as packed groups.
  task automatic test_reset();
    #2;
    vectors++;
    if ({imem_req, imem_addr, id_valid, id_pc, id_instr} !== {1'b0, 12'h000, 1'b0, 12'h000, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_values got req=%b addr=%h v=%b pc=%h instr=%h", imem_req, imem_addr, id_valid, id_pc, id_instr);
    end
    tick();
    rst_n = 1'b1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_req got %b want 0", imem_req);
    end
    tick();
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 12'h000}) begin
      miscompares++;
      $display("FAIL reset_first_fetch got req=%b addr=%h want 1/000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    imem_ack = 1'b1; imem_data = 32'h1111_1111;
    tick();
    vectors++;
    if ({id_valid, id_pc, id_instr, id_imm17, imem_addr} !== {1'b1, 12'h001, 32'h1111_1111, 17'h11111, 12'h001}) begin
      miscompares++;
      $display("FAIL stream_1 got v=%b pc=%h instr=%h imm=%h addr=%h", id_valid, id_pc, id_instr, id_imm17, imem_addr);
    end
    imem_data = 32'h2222_2222;
    tick();
    vectors++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 12'h002, 32'h2222_2222}) begin
      miscompares++;
      $display("FAIL stream_2 got v=%b pc=%h instr=%h", id_valid, id_pc, id_instr);
    end
    imem_data = 32'h3333_3333;
    tick();
    vectors++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 12'h003, 32'h3333_3333}) begin
      miscompares++;
      $display("FAIL stream_3 got v=%b pc=%h instr=%h", id_valid, id_pc, id_instr);
    end
    imem_ack = 1'b0;
    tick();
    vectors++;
    if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 12'h003}) begin
      miscompares++;
      $display("FAIL stream_idle got v=%b req=%b addr=%h want 0/1/003", id_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; imem_ack = 1'b1; imem_data = 32'hA4A4_A4A4;
    tick();
    vectors++;
    if ({id_valid, id_pc, id_instr, imem_req, imem_addr} !== {1'b1, 12'h004, 32'hA4A4_A4A4, 1'b1, 12'h004}) begin
      miscompares++;
      $display("FAIL stall_load_empty got v=%b pc=%h instr=%h req=%b addr=%h", id_valid, id_pc, id_instr, imem_req, imem_addr);
    end
    imem_data = 32'hB5B5_B5B5;
    tick();
    vectors++;
    if ({id_valid, id_pc, id_instr, imem_req} !== {1'b1, 12'h004, 32'hA4A4_A4A4, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_skid_fill got v=%b pc=%h instr=%h req=%b", id_valid, id_pc, id_instr, imem_req);
    end
    imem_ack = 1'b0;
    tick();
    vectors++;
    if ({id_valid, id_pc, imem_req} !== {1'b1, 12'h004, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_hold got v=%b pc=%h req=%b", id_valid, id_pc, imem_req);
    end
    stall = 1'b0;
    tick();
    vectors++;
    if ({id_valid, id_pc, id_instr, imem_req, imem_addr} !== {1'b1, 12'h005, 32'hB5B5_B5B5, 1'b1, 12'h005}) begin
      miscompares++;
      $display("FAIL stall_drain got v=%b pc=%h instr=%h req=%b addr=%h", id_valid, id_pc, id_instr, imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_data = 32'hC6C6_C6C6;
    tick();
    vectors++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 12'h006, 32'hC6C6_C6C6}) begin
      miscompares++;
      $display("FAIL stall_next got v=%b pc=%h instr=%h", id_valid, id_pc, id_instr);
    end
    imem_ack = 1'b0;
    tick();
  endtask

  task automatic test_redirect_drop();
    // Redirect coincident with ack: ack is discarded, refetch at 0x005.
    redir = 1'b1; redir_pc = 12'h005; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    tick();
    redir = 1'b0; imem_ack = 1'b0;
    vectors++;
    if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 12'h005}) begin
      miscompares++;
      $display("FAIL redir_ack_to_005 got v=%b req=%b addr=%h", id_valid, imem_req, imem_addr);
    end
    tick();
    redir = 1'b1; redir_pc = 12'h0A0;
    tick();
    redir = 1'b0;
    vectors++;
    if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b0, 12'h0A0}) begin
      miscompares++;
      $display("FAIL redir_enter_drop got v=%b req=%b addr=%h", id_valid, imem_req, imem_addr);
    end
    tick();
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_drop_wait got req=%b want 0", imem_req);
    end
    imem_ack = 1'b1; imem_data = 32'hBADB_AD00;
    tick();
    imem_ack = 1'b0;
    vectors++;
    if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 12'h0A0}) begin
      miscompares++;
      $display("FAIL redir_drop_discard got v=%b req=%b addr=%h", id_valid, imem_req, imem_addr);
    end
    tick();
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_still_empty got v=%b want 0", id_valid);
    end
    imem_ack = 1'b1; imem_data = 32'h0000_A0A0;
    tick();
    imem_ack = 1'b0;
    vectors++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 12'h0A1, 32'h0000_A0A0}) begin
      miscompares++;
      $display("FAIL redir_target_fetch got v=%b pc=%h instr=%h", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_redirect_ack_stall();
    stall = 1'b1; imem_ack = 1'b1; imem_data = 32'hE0E0_E0E0; redir = 1'b1; redir_pc = 12'h200;
    tick();
    redir = 1'b0; imem_ack = 1'b0;
    vectors++;
    if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 12'h200}) begin
      miscompares++;
      $display("FAIL redir_stall_ack got v=%b req=%b addr=%h", id_valid, imem_req, imem_addr);
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_skid_empty got v=%b want 0", id_valid);
    end
    imem_ack = 1'b1; imem_data = 32'hF0F0_F0F0;
    tick();
    vectors++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 12'h201, 32'hF0F0_F0F0}) begin
      miscompares++;
      $display("FAIL redir_200_fetch got v=%b pc=%h instr=%h", id_valid, id_pc, id_instr);
    end
    stall = 1'b1; imem_data = 32'h1212_1212;
    tick();
    imem_ack = 1'b0;
    vectors++;
    if ({id_pc, imem_req} !== {12'h201, 1'b0}) begin
      miscompares++;
      $display("FAIL redir_skid_full got pc=%h req=%b", id_pc, imem_req);
    end
    // Redirect with a full skid: skid must be flushed so requests resume.
    redir = 1'b1; redir_pc = 12'hFFF;
    tick();
    redir = 1'b0;
    vectors++;
    if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 12'hFFF}) begin
      miscompares++;
      $display("FAIL redir_flush_skid got v=%b req=%b addr=%h", id_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    stall = 1'b0; imem_ack = 1'b1; imem_data = 32'hFF65_4321;
    tick();
    vectors++;
    if ({id_valid, id_pc, id_instr, id_tgt27, id_imm17, imem_addr} !== {1'b1, 12'h000, 32'hFF65_4321, 27'h7654321, 17'h14321, 12'h000}) begin
      miscompares++;
      $display("FAIL wrap_fff got v=%b pc=%h instr=%h tgt=%h imm=%h addr=%h", id_valid, id_pc, id_instr, id_tgt27, id_imm17, imem_addr);
    end
    imem_data = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    vectors++;
    if ({id_valid, id_pc, id_tgt27, imem_addr} !== {1'b1, 12'h001, 27'h2345678, 12'h001}) begin
      miscompares++;
      $display("FAIL wrap_000 got v=%b pc=%h tgt=%h addr=%h", id_valid, id_pc, id_tgt27, imem_addr);
    end
  endtask

  task automatic test_reset_midfetch();
    imem_ack = 1'b1; imem_data = 32'h9999_9999;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({imem_req, imem_addr, id_valid, id_pc, id_instr} !== {1'b0, 12'h000, 1'b0, 12'h000, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_async got req=%b addr=%h v=%b pc=%h instr=%h", imem_req, imem_addr, id_valid, id_pc, id_instr);
    end
    imem_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({imem_req, imem_addr, id_valid} !== {1'b1, 12'h000, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_refetch got req=%b addr=%h v=%b", imem_req, imem_addr, id_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_ack_stall();
    test_wrap();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
